bt656_timing_decoder: RTL and testbench

- Upstream neighbour of the line rotation scrambler/descrambler. It sits between the TVP5147M1 10-bit BT.656 output and line_rotator.
- Detects embedded timing reference sequences (TRS: 3FF 000 000 XYZ) and validates the XYZ protection bits.
- Regenerates the H, V and F flags, aligned to a fixed-latency copy of the video stream, so that H falls exactly on the first active sample after SAV.
- Provides sync-lock and error status for the downstream crypto stages.

---
 rtl/bt656_timing_decoder.sv | 176 +++++++++++++++++
 tb/tb_bt656_timing_decoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bt656_timing_decoder.sv
// BT.656 timing reference decoder: finds TRS codes, checks XYZ protection bits and
// regenerates H/V/F aligned to a fixed 4-clock copy of the word stream, with lock status.
module bt656_timing_decoder #(
  parameter int TIMEOUT    = 2048,
  parameter int LOCK_LINES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] data_in,
  output logic [9:0] data_out,
  output logic       h_out,
  output logic       v_out,
  output logic       f_out,
  output logic       trs_out,
  output logic       trs_error,
  output logic [7:0] err_count,
  output logic       locked
);

  // The detection window and flag alignment below are built around exactly four stages.
  localparam int LATENCY = 4;
  localparam int CW = $clog2(LOCK_LINES + 1);
  localparam logic [11:0]   TIMEOUT_C    = 12'(TIMEOUT);
  localparam logic [CW-1:0] LOCK_LINES_C = CW'(LOCK_LINES);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  function automatic logic xyz_valid(input logic [9:0] w);
    logic f_b, v_b, h_b;
    f_b = w[8];
    v_b = w[7];
    h_b = w[6];
    return w[9] && (w[1:0] == 2'b00) && (w[5] == (v_b ^ h_b)) && (w[4] == (f_b ^ h_b)) &&
           (w[3] == (f_b ^ v_b)) && (w[2] == (f_b ^ v_b ^ h_b));
  endfunction

  logic [9:0]  pipe_r [0:LATENCY-1];
  logic        pre_s, trs_ok_s, trs_bad_s, eav_s, timeout_s;
  logic [2:0]  trs_left_r, trs_left_s;
  logic [2:0]  pend_r, pend_s;
  logic        h_r, v_r, f_r, h_s, v_s, f_s;
  logic        trs_r, trs_s, err_r;
  logic [7:0]  cnt_r, cnt_s;
  logic [11:0] to_cnt_r, to_cnt_s;
  lock_state_e state_r, state_s;
  logic [CW-1:0] eav_cnt_r, eav_cnt_s, eav_inc_s;
  logic        locked_r;

  // The preamble sits in the delay line while the XYZ word is still on data_in,
  // so the flags can be registered in step with the 3FF word leaving the pipe.
  assign pre_s     = (pipe_r[2] == 10'h3FF) && (pipe_r[1] == 10'h000) && (pipe_r[0] == 10'h000);
  assign trs_ok_s  = pre_s && xyz_valid(data_in);
  assign trs_bad_s = pre_s && !xyz_valid(data_in);
  assign eav_s     = trs_ok_s && data_in[6];
  assign timeout_s = !trs_ok_s && (to_cnt_r >= TIMEOUT_C);
  assign eav_inc_s = eav_cnt_r + CW'(1);

  // Word delay line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) pipe_r[i] <= 10'd0;
    end else begin
      pipe_r[0] <= data_in;
      for (int i = 1; i < LATENCY; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  // Flag, TRS-tag, error and timeout next-state logic.
  always_comb begin
    trs_left_s = trs_left_r;
    trs_s      = 1'b0;
    h_s        = h_r;
    v_s        = v_r;
    f_s        = f_r;
    pend_s     = pend_r;
    if (trs_ok_s) begin
      trs_left_s = 3'd4;
      trs_s      = 1'b1;
      h_s        = 1'b1;
      pend_s     = data_in[8:6];
    end else if (trs_left_r > 3'd1) begin
      trs_left_s = trs_left_r - 3'd1;
      trs_s      = 1'b1;
    end else if (trs_left_r == 3'd1) begin
      trs_left_s        = 3'd0;
      {f_s, v_s, h_s}   = pend_r;
    end else if (timeout_s) begin
      h_s = 1'b1;
    end else begin
      h_s = h_r;
    end

    if (trs_bad_s && (cnt_r != 8'hFF)) begin
      cnt_s = cnt_r + 8'd1;
    end else begin
      cnt_s = cnt_r;
    end

    if (trs_ok_s) begin
      to_cnt_s = 12'd0;
    end else if (to_cnt_r != 12'hFFF) begin
      to_cnt_s = to_cnt_r + 12'd1;
    end else begin
      to_cnt_s = to_cnt_r;
    end
  end

  // Lock FSM next state: errors and timeouts dominate, EAVs advance acquisition.
  always_comb begin
    state_s   = state_r;
    eav_cnt_s = eav_cnt_r;
    if (trs_bad_s || timeout_s) begin
      state_s   = UNLOCKED;
      eav_cnt_s = {CW{1'b0}};
    end else if (eav_s) begin
      case (state_r)
        UNLOCKED, ACQUIRE: begin
          eav_cnt_s = eav_inc_s;
          state_s   = (eav_inc_s >= LOCK_LINES_C) ? LOCKED : ACQUIRE;
        end
        LOCKED:  state_s = LOCKED;
        default: begin
          state_s   = UNLOCKED;
          eav_cnt_s = {CW{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trs_left_r <= 3'd0;
      pend_r     <= 3'b011;
      h_r        <= 1'b1;
      v_r        <= 1'b1;
      f_r        <= 1'b0;
      trs_r      <= 1'b0;
      err_r      <= 1'b0;
      cnt_r      <= 8'd0;
      to_cnt_r   <= 12'd0;
      state_r    <= UNLOCKED;
      eav_cnt_r  <= {CW{1'b0}};
      locked_r   <= 1'b0;
    end else begin
      trs_left_r <= trs_left_s;
      pend_r     <= pend_s;
      h_r        <= h_s;
      v_r        <= v_s;
      f_r        <= f_s;
      trs_r      <= trs_s;
      err_r      <= trs_bad_s;
      cnt_r      <= cnt_s;
      to_cnt_r   <= to_cnt_s;
      state_r    <= state_s;
      eav_cnt_r  <= eav_cnt_s;
      locked_r   <= (state_s == LOCKED);
    end
  end

  assign data_out  = pipe_r[LATENCY-1];
  assign h_out     = h_r;
  assign v_out     = v_r;
  assign f_out     = f_r;
  assign trs_out   = trs_r;
  assign trs_error = err_r;
  assign err_count = cnt_r;
  assign locked    = locked_r;

endmodule

// File: tb/tb_bt656_timing_decoder.sv
// Scoreboard bench for bt656_timing_decoder: directed BT.656 lines with hand-specified flags.
module tb_bt656_timing_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] data_in;
  logic [9:0] data_out;
  logic       h_out, v_out, f_out, trs_out, trs_error, locked;
  logic [7:0] err_count;

  bt656_timing_decoder dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_out(data_out),
    .h_out(h_out), .v_out(v_out), .f_out(f_out), .trs_out(trs_out),
    .trs_error(trs_error), .err_count(err_count), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [13:0] exp; } vid_t;
  typedef struct { int due; logic [9:0]  exp; } st_t;

  vid_t vq[$];
  st_t  sq[$];
  vid_t vi;
  st_t  si;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic       exp_err  = 1'b0;
  logic [7:0] exp_cnt  = 8'd0;
  logic       exp_lock = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: video expectations are due 4 cycles after the word, status 1 cycle after.
  always @(negedge clk) begin
    if (vq.size() > 0 && vq[0].due == cyc) begin
      vi = vq.pop_front();
      n_cmp++;
      if ({data_out, h_out, v_out, f_out, trs_out} !== vi.exp) begin
        n_bad++;
        $display("FAIL video cyc=%0d: got data=%h hvf_trs=%b want data=%h hvf_trs=%b",
                 cyc, data_out, {h_out, v_out, f_out, trs_out}, vi.exp[13:4], vi.exp[3:0]);
      end
    end
    if (sq.size() > 0 && sq[0].due == cyc) begin
      si = sq.pop_front();
      n_cmp++;
      if ({trs_error, err_count, locked} !== si.exp) begin
        n_bad++;
        $display("FAIL status cyc=%0d: got err=%b cnt=%0d lock=%b want err=%b cnt=%0d lock=%b",
                 cyc, trs_error, err_count, locked, si.exp[9], si.exp[8:1], si.exp[0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst data_out", data_out, 10'd0);
    chk("rst h_out", {9'd0, h_out}, 10'd1);
    chk("rst v_out", {9'd0, v_out}, 10'd1);
    chk("rst f_out", {9'd0, f_out}, 10'd0);
    chk("rst trs_out", {9'd0, trs_out}, 10'd0);
    chk("rst trs_error", {9'd0, trs_error}, 10'd0);
    chk("rst err_count", {2'd0, err_count}, 10'd0);
    chk("rst locked", {9'd0, locked}, 10'd0);
  endtask

  task automatic drive(input logic [9:0] w, input logic h, input logic v, input logic f,
                       input logic trs);
    vid_t a;
    st_t  b;
    @(posedge clk);
    #1;
    data_in = w;
    a.due = cyc + 4;
    a.exp = {w, h, v, f, trs};
    vq.push_back(a);
    b.due = cyc + 1;
    b.exp = {exp_err, exp_cnt, exp_lock};
    sq.push_back(b);
    exp_err = 1'b0;
  endtask

  task automatic blank(input int n, input logic h, input logic v, input logic f);
    for (int i = 0; i < n; i++) drive((i % 2 == 0) ? 10'h200 : 10'h040, h, v, f, 1'b0);
  endtask

  task automatic samples(input int n, input logic h, input logic v, input logic f);
    for (int i = 0; i < n; i++) drive(10'h100 + 10'(i % 200), h, v, f, 1'b0);
  endtask

  // oh/ov/of: flags in force before this TRS; lk: locked expected once XYZ is registered.
  task automatic trs(input logic [9:0] xyz, input logic ok, input logic oh, input logic ov,
                     input logic of, input logic lk, input logic err);
    logic th;
    th = ok ? 1'b1 : oh;
    drive(10'h3FF, th, ov, of, ok);
    drive(10'h000, th, ov, of, ok);
    drive(10'h000, th, ov, of, ok);
    exp_err  = err;
    exp_lock = lk;
    if (err) exp_cnt = exp_cnt + 8'd1;
    drive(xyz, th, ov, of, ok);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    data_in = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    reset_n = 1'b1;

    // Clean NTSC line, then a second EAV that completes lock
    blank(8, 1'b1, 1'b1, 1'b0);
    trs(10'h274, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    blank(268, 1'b1, 1'b0, 1'b0);
    trs(10'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    samples(1440, 1'b0, 1'b0, 1'b0);
    trs(10'h274, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    blank(268, 1'b1, 1'b0, 1'b0);

    // Corrupted SAV: error pulse, unlock, line stays blanked
    trs(10'h204, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    samples(1440, 1'b1, 1'b0, 1'b0);

    // 3B0 decodes F=1 V=1 H=0; 31C decodes F=1 V=0 H=0
    trs(10'h3B0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    samples(16, 1'b0, 1'b1, 1'b1);
    trs(10'h31C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    samples(16, 1'b0, 1'b0, 1'b1);

    // Overlapping preamble 3FF 3FF 000 000 274
    drive(10'h3FF, 1'b0, 1'b0, 1'b1, 1'b0);
    trs(10'h274, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    blank(8, 1'b1, 1'b0, 1'b0);

    // ANC preamble never matches
    drive(10'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(10'h155, 1'b1, 1'b0, 1'b0, 1'b0);
    blank(8, 1'b1, 1'b0, 1'b0);

    // Relock, then starve of TRS until timeout
    trs(10'h274, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    blank(20, 1'b1, 1'b0, 1'b0);
    trs(10'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 2100; k++) begin
      exp_lock = (k <= 2048);
      drive(10'h100 + 10'(k % 200), (k >= 2046), 1'b0, 1'b0, 1'b0);
    end

    // Reset during the 700th active sample
    trs(10'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    samples(699, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    data_in = 10'h2BB;
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    vq.delete();
    sq.delete();
    exp_err  = 1'b0;
    exp_cnt  = 8'd0;
    exp_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    samples(50, 1'b1, 1'b1, 1'b0);
    trs(10'h200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    samples(20, 1'b0, 1'b0, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (vq.size() != 0 || sq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", vq.size(), sq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
